bch_berlekamp_ctrl: RTL and testbench

- Control FSM that sequences a serial (one-multiply-per-cycle) inversionless binary Berlekamp-Massey datapath for the BCH decoder.
- Sits between the syndrome calculator and the Chien search.
- Accepts a syndrome block by handshake, steps the datapath through T iterations (delta accumulate, then polynomial update), and tracks the locator length L.
- Presents the finished locator with degree and decoder-failure flag, holding it until downstream accepts.

---
 rtl/bch_pkg.sv | 34 +++
 rtl/bch_berlekamp_ctrl.sv | 159 +++++++++++++++
 tb/tb_bch_berlekamp_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bch_pkg.sv
// Shared definitions for the BCH Berlekamp-Massey controller: FSM states,
// default T-derived widths and the iteration schedule helpers.
package bch_pkg;

  // Default error-correction capability and the widths it implies.
  localparam int T_DEFAULT  = 8;
  localparam int JW_DEFAULT = $clog2(T_DEFAULT + 1);
  localparam int LW_DEFAULT = $clog2(2 * T_DEFAULT + 1);

  // Controller phases.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ACC  = 3'd2,
    UPD  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Highest term index accumulated into delta during iteration r.
  function automatic int jmax(input int r, input int t);
    return (2 * r < t) ? 2 * r : t;
  endfunction

  // Cycles from the accept edge until the locator becomes valid.
  function automatic int bm_latency(input int t);
    int s;
    s = 1;
    for (int r = 0; r < t; r++) begin
      s += jmax(r, t) + 2;
    end
    return s;
  endfunction

endpackage

// File: rtl/bch_berlekamp_ctrl.sv
// Sequencer for a serial inversionless binary Berlekamp-Massey datapath.
// Accepts a syndrome block, runs T iterations of (delta accumulate, update),
// tracks the locator length L and presents the final degree until accepted.
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high (isyndrome_val/osyndrome_rdy upstream, oloc_val/iloc_rdy
// downstream); valid outputs stay asserted and stable until that edge.
module bch_berlekamp_ctrl
  import bch_pkg::*;
#(
  parameter int T  = 8,
  parameter int JW = $clog2(T + 1),
  parameter int LW = $clog2(2 * T + 1)
) (
  input  logic          iclk,
  input  logic          ireset,
  input  logic          isyndrome_val,
  output logic          osyndrome_rdy,
  output logic          osyn_load,
  output logic          odelta_clr,
  output logic          odelta_acc,
  output logic [JW-1:0] oj,
  output logic [JW-1:0] or_idx,
  input  logic          idelta_nz,
  output logic          oupd,
  output logic          ob_sel,
  output logic          oloc_val,
  input  logic          iloc_rdy,
  output logic [LW-1:0] oloc_deg,
  output logic          odecfail,
  output state_t        ostate_dbg
);

  state_t        state_q, state_d;
  logic [JW-1:0] j_q, j_d;
  logic [JW-1:0] r_q, r_d;
  logic [LW-1:0] l_q, l_d;

  logic [JW-1:0] jmax_r;
  logic          last_iter;
  logic          take_upd;
  logic [LW:0]   r_ext;
  logic [LW:0]   l_ext;
  logic [LW:0]   l_alt;
  logic [LW-1:0] l_sat;

  // Schedule bounds for the current iteration.
  assign jmax_r    = JW'(jmax(int'(r_q), T));
  assign last_iter = (r_q == JW'(T - 1));

  // Length change 2r+1-L, one bit wider than L; the L<=r guard keeps it
  // non-negative, and the clamp keeps L within 2T.
  assign r_ext = (LW + 1)'(r_q);
  assign l_ext = {1'b0, l_q};
  assign l_alt = (r_ext << 1) + (LW + 1)'(1) - l_ext;
  assign l_sat = (l_alt > (LW + 1)'(2 * T)) ? LW'(2 * T) : l_alt[LW-1:0];

  // The b_poly swap happens only when delta is non-zero and L<=r.
  assign take_upd = (state_q == UPD) && idelta_nz && (l_ext <= r_ext);

  // State, counters and locator length registers.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q <= IDLE;
      j_q     <= '0;
      r_q     <= '0;
      l_q     <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      r_q     <= r_d;
      l_q     <= l_d;
    end
  end

  // Next-state logic and Moore strobes decoded from the registered state.
  always_comb begin
    state_d       = state_q;
    j_d           = j_q;
    r_d           = r_q;
    l_d           = l_q;
    osyndrome_rdy = 1'b0;
    osyn_load     = 1'b0;
    odelta_clr    = 1'b0;
    odelta_acc    = 1'b0;
    oupd          = 1'b0;
    oloc_val      = 1'b0;
    oloc_deg      = '0;
    odecfail      = 1'b0;

    case (state_q)
      IDLE: begin
        osyndrome_rdy = 1'b1;
        if (isyndrome_val) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        osyn_load = 1'b1;
        l_d       = '0;
        r_d       = '0;
        j_d       = '0;
        state_d   = ACC;
      end

      ACC: begin
        odelta_acc = 1'b1;
        odelta_clr = (j_q == '0);
        if (j_q < jmax_r) begin
          j_d = j_q + 1'b1;
        end else begin
          state_d = UPD;
        end
      end

      UPD: begin
        oupd = 1'b1;
        if (take_upd) begin
          l_d = l_sat;
        end
        if (last_iter) begin
          state_d = DONE;
        end else begin
          r_d     = r_q + 1'b1;
          j_d     = '0;
          state_d = ACC;
        end
      end

      DONE: begin
        oloc_val = 1'b1;
        oloc_deg = l_q;
        odecfail = (l_q > LW'(T));
        if (iloc_rdy) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ob_sel     = take_upd;
  assign oj         = j_q;
  assign or_idx     = r_q;
  assign ostate_dbg = state_q;

  // Structural invariants of the controller registers.
  a_len_bound : assert property (@(posedge iclk) disable iff (ireset)
    l_q <= LW'(2 * T));
  a_j_bound : assert property (@(posedge iclk) disable iff (ireset)
    (state_q == ACC) |-> (j_q <= jmax_r));
  a_r_bound : assert property (@(posedge iclk) disable iff (ireset)
    r_q <= JW'(T - 1));

endmodule

// File: tb/tb_bch_berlekamp_ctrl.sv
// Bench for bch_berlekamp_ctrl: three instances (T=8, 4, 2) behind a select
// mux, a per-cycle schedule model, a vector table and hand-written sequences
// for reset and ignored-input corners.
module tb_bch_berlekamp_ctrl;
  import bch_pkg::*;

  // ---------------- clock / reset ----------------
  logic iclk;
  logic ireset;
  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  logic       syn_val, delta_nz, loc_rdy;
  logic [1:0] sel;

  logic   rdy_w[3], load_w[3], clr_w[3], acc_w[3], upd_w[3];
  logic   bsel_w[3], val_w[3], fail_w[3];
  state_t st_w[3];
  logic [3:0] j8, r8;
  logic [4:0] deg8;
  logic [2:0] j4, r4;
  logic [3:0] deg4;
  logic [1:0] j2, r2;
  logic [2:0] deg2;

  bch_berlekamp_ctrl #(.T(8)) u_t8 (
    .iclk(iclk), .ireset(ireset),
    .isyndrome_val(syn_val && sel == 2'd0), .osyndrome_rdy(rdy_w[0]),
    .osyn_load(load_w[0]), .odelta_clr(clr_w[0]), .odelta_acc(acc_w[0]),
    .oj(j8), .or_idx(r8), .idelta_nz(delta_nz), .oupd(upd_w[0]),
    .ob_sel(bsel_w[0]), .oloc_val(val_w[0]),
    .iloc_rdy(loc_rdy && sel == 2'd0), .oloc_deg(deg8),
    .odecfail(fail_w[0]), .ostate_dbg(st_w[0])
  );

  bch_berlekamp_ctrl #(.T(4)) u_t4 (
    .iclk(iclk), .ireset(ireset),
    .isyndrome_val(syn_val && sel == 2'd1), .osyndrome_rdy(rdy_w[1]),
    .osyn_load(load_w[1]), .odelta_clr(clr_w[1]), .odelta_acc(acc_w[1]),
    .oj(j4), .or_idx(r4), .idelta_nz(delta_nz), .oupd(upd_w[1]),
    .ob_sel(bsel_w[1]), .oloc_val(val_w[1]),
    .iloc_rdy(loc_rdy && sel == 2'd1), .oloc_deg(deg4),
    .odecfail(fail_w[1]), .ostate_dbg(st_w[1])
  );

  bch_berlekamp_ctrl #(.T(2)) u_t2 (
    .iclk(iclk), .ireset(ireset),
    .isyndrome_val(syn_val && sel == 2'd2), .osyndrome_rdy(rdy_w[2]),
    .osyn_load(load_w[2]), .odelta_clr(clr_w[2]), .odelta_acc(acc_w[2]),
    .oj(j2), .or_idx(r2), .idelta_nz(delta_nz), .oupd(upd_w[2]),
    .ob_sel(bsel_w[2]), .oloc_val(val_w[2]),
    .iloc_rdy(loc_rdy && sel == 2'd2), .oloc_deg(deg2),
    .odecfail(fail_w[2]), .ostate_dbg(st_w[2])
  );

  // Selected instance, widened to the T=8 widths.
  logic   m_rdy, m_load, m_clr, m_acc, m_upd, m_bsel, m_val, m_fail;
  state_t m_st;
  logic [3:0] m_j, m_r;
  logic [4:0] m_deg;

  always_comb begin
    m_rdy  = rdy_w[sel];
    m_load = load_w[sel];
    m_clr  = clr_w[sel];
    m_acc  = acc_w[sel];
    m_upd  = upd_w[sel];
    m_bsel = bsel_w[sel];
    m_val  = val_w[sel];
    m_fail = fail_w[sel];
    m_st   = st_w[sel];
    case (sel)
      2'd1:    begin m_j = {1'b0, j4};  m_r = {1'b0, r4};  m_deg = {1'b0, deg4}; end
      2'd2:    begin m_j = {2'b0, j2};  m_r = {2'b0, r2};  m_deg = {2'b0, deg2}; end
      default: begin m_j = j8;          m_r = r8;          m_deg = deg8;         end
    endcase
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [20:0] exp_q[$];
  logic [2:0]  in_q[$];   // {isyndrome_val, idelta_nz, iloc_rdy} per cycle

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [20:0] mk(bit rdy, bit load, bit clr, bit acc, bit upd,
                                     bit bsel, bit val, bit fail, int deg, int j, int r);
    return {rdy, load, clr, acc, upd, bsel, val, fail, 5'(deg), 4'(j), 4'(r)};
  endfunction

  // j and r are only meaningful alongside an accumulate or update strobe.
  function automatic logic [20:0] obs();
    logic idx_ok;
    idx_ok = m_acc | m_upd;
    return {m_rdy, m_load, m_clr, m_acc, m_upd, m_bsel, m_val, m_fail, m_deg,
            idx_ok ? m_j : 4'd0, idx_ok ? m_r : 4'd0};
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] sel_of(input int t);
    return (t == 8) ? 2'd0 : (t == 4) ? 2'd1 : 2'd2;
  endfunction

  // Reference schedule: accept, load, then for each iteration r the terms
  // j=0..min(2r,T) followed by one update; L follows the BM length rule.
  // Inputs the controller must ignore are randomized.
  task automatic build(input int t, input int pat, input int hold, output int deg);
    int l;
    int jm;
    bit d;
    bit bs;
    exp_q.delete();
    in_q.delete();
    l = 0;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    in_q.push_back({1'b1, rb(), rb()});
    exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    in_q.push_back({rb(), rb(), rb()});
    for (int r = 0; r < t; r++) begin
      jm = (2 * r < t) ? 2 * r : t;
      for (int j = 0; j <= jm; j++) begin
        exp_q.push_back(mk(0, 0, j == 0, 1, 0, 0, 0, 0, 0, j, r));
        in_q.push_back({rb(), rb(), rb()});
      end
      d  = pat[r];
      bs = d && (l <= r);
      exp_q.push_back(mk(0, 0, 0, 0, 1, bs, 0, 0, 0, jm, r));
      in_q.push_back({rb(), d, rb()});
      if (bs) l = 2 * r + 1 - l;
    end
    for (int h = 0; h <= hold; h++) begin
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, l > t, l, 0, 0));
      in_q.push_back({rb(), rb(), h == hold});
    end
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    in_q.push_back({1'b0, rb(), rb()});
    deg = l;
  endtask

  // ---------------- driver ----------------
  task automatic run_block(input int t, input int pat, input int hold,
                           output int deg_obs, output int fail_obs,
                           output int lat_obs, output int deg_model);
    build(t, pat, hold, deg_model);
    lat_obs  = -1;
    deg_obs  = -1;
    fail_obs = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge iclk);
      sel = sel_of(t);
      {syn_val, delta_nz, loc_rdy} = in_q[i];
      #1;
      if (lat_obs < 0 && m_val) begin
        lat_obs  = i - 1;
        deg_obs  = int'(m_deg);
        fail_obs = int'(m_fail);
      end
      check($sformatf("cycle t=%0d pat=%0h i=%0d", t, pat, i), 32'(obs()), 32'(exp_q[i]));
    end
  endtask

  typedef struct {
    int t;
    int pat;
    int hold;
    int deg;
    int fail;
    int lat;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int deg_o, fail_o, lat_o, deg_m;
    int loads;
    bit found;

    // pat bit r is the datapath delta-nonzero flag at the update of iteration r
    tbl[0] = '{t: 8, pat: 'h00, hold: 0,  deg: 0,  fail: 0, lat: 61};
    tbl[1] = '{t: 4, pat: 'hF,  hold: 2,  deg: 4,  fail: 0, lat: 19};
    tbl[2] = '{t: 2, pat: 'h2,  hold: 10, deg: 3,  fail: 1, lat: 7};   // L: 0, then 2*1+1-0
    tbl[3] = '{t: 2, pat: 'h3,  hold: 0,  deg: 2,  fail: 0, lat: 7};
    tbl[4] = '{t: 8, pat: 'hFF, hold: 1,  deg: 8,  fail: 0, lat: 61};
    tbl[5] = '{t: 8, pat: 'h80, hold: 3,  deg: 15, fail: 1, lat: 61};
    tbl[6] = '{t: 4, pat: 'h8,  hold: 0,  deg: 7,  fail: 1, lat: 19};
    tbl[7] = '{t: 8, pat: 'h02, hold: 0,  deg: 3,  fail: 0, lat: 61};

    ireset   = 1'b1;
    syn_val  = 1'b0;
    delta_nz = 1'b0;
    loc_rdy  = 1'b0;
    sel      = 2'd0;

    // Reset state on every instance.
    repeat (3) @(negedge iclk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check($sformatf("reset_outputs sel=%0d", s), 32'(obs()),
            32'(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      check($sformatf("reset_state sel=%0d", s), 32'(m_st), 32'(IDLE));
    end
    @(negedge iclk);
    ireset = 1'b0;
    repeat (2) @(negedge iclk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check($sformatf("idle_after_reset sel=%0d", s), 32'(obs()),
            32'(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    end

    // Table-driven blocks.
    for (int k = 0; k < 8; k++) begin
      run_block(tbl[k].t, tbl[k].pat, tbl[k].hold, deg_o, fail_o, lat_o, deg_m);
      check($sformatf("tbl%0d_deg", k), 32'(deg_o), 32'(tbl[k].deg));
      check($sformatf("tbl%0d_fail", k), 32'(fail_o), 32'(tbl[k].fail));
      check($sformatf("tbl%0d_lat", k), 32'(lat_o), 32'(tbl[k].lat));
      check($sformatf("tbl%0d_lat_fn", k), 32'(lat_o), 32'(bm_latency(tbl[k].t)));
    end

    // Randomized blocks against the schedule model.
    for (int k = 0; k < 6; k++) begin
      int tsel, t, pat, hold;
      tsel = $urandom_range(0, 2);
      t    = (tsel == 0) ? 8 : (tsel == 1) ? 4 : 2;
      pat  = $urandom_range(0, (1 << t) - 1);
      hold = $urandom_range(0, 4);
      run_block(t, pat, hold, deg_o, fail_o, lat_o, deg_m);
      check($sformatf("rnd%0d_deg", k), 32'(deg_o), 32'(deg_m));
      check($sformatf("rnd%0d_fail", k), 32'(fail_o), 32'(deg_m > t));
      check($sformatf("rnd%0d_lat", k), 32'(lat_o), 32'(bm_latency(t)));
    end

    // Ignored isyndrome_val during ACC, then reset in UPD of r=3.
    @(negedge iclk);
    sel     = 2'd0;
    syn_val = 1'b1;
    loc_rdy = 1'b0;
    loads   = 0;
    found   = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge iclk);
      syn_val  = (k == 3);
      delta_nz = rb();
      #1;
      if (m_load) loads++;
      if (m_upd && m_r == 4'd3) found = 1'b1;
    end
    check("midrun_reached_upd_r3", 32'(found), 32'd1);
    check("midrun_single_load", 32'(loads), 32'd1);
    #2;
    ireset = 1'b1;
    #1;
    check("async_reset_outputs", 32'(obs()), 32'(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    check("async_reset_state", 32'(m_st), 32'(IDLE));
    @(negedge iclk);
    ireset  = 1'b0;
    syn_val = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge iclk);
      #1;
      check($sformatf("post_reset_idle%0d", k), 32'(obs()),
            32'(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    end
    run_block(8, $urandom_range(0, 255), 1, deg_o, fail_o, lat_o, deg_m);
    check("post_reset_lat", 32'(lat_o), 32'd61);
    check("post_reset_deg", 32'(deg_o), 32'(deg_m));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
